if_fetch_stage: RTL and testbench

//  Instruction-fetch stage ahead of the IF/ID pipeline register of the 16-bit CPU.
//  - Owns the PC and drives a request/ready instruction-memory port; memory may respond in the request cycle or later.
//  - Delivers instr + PC+2 to IF/ID with a write strobe; honours hazard-unit stalls.
//  - Applies branch/jump redirects from EX and generates the IF/ID flush.

---
 rtl/if_fetch_stage_if.sv | 31 +++
 rtl/if_fetch_stage.sv | 228 ++++++++++++++++++++++
 tb/tb_if_fetch_stage.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_stage_if.sv
// ============================================================================
// if_fetch_stage_if
// Purpose : instruction-memory request/ready port between the fetch stage and
//           the instruction memory.
// Signals :
//   imem_req    fetch request (fetch stage -> memory)
//   imem_addr   fetch byte address, held stable while req=1 and ready=0
//   imem_ready  response valid this cycle (memory -> fetch stage)
//   imem_rdata  instruction word, valid when ready=1
// Modports: master = fetch stage, slave = instruction memory.
// ============================================================================
interface if_fetch_stage_if;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready;
    logic [15:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/if_fetch_stage.sv
// ============================================================================
// if_fetch_stage
// Purpose : instruction-fetch stage ahead of the IF/ID register of the 16-bit
//           CPU. Owns the PC, issues requests on a request/ready instruction
//           memory port (zero or more wait states), delivers instr + PC+2 to
//           IF/ID with a write strobe, honours hazard stalls, applies EX
//           redirects and generates the IF/ID flush.
// Ports   :
//   clk_i          clock, all state on rising edge
//   rst_n          asynchronous active-low reset
//   PCwrite_i      1 = IF/ID may advance, 0 = stall
//   redirect_i     taken branch/jump resolved in EX
//   redirect_pc_i  redirect target (bit 0 forced to 0)
//   imem           instruction-memory port (master side)
//   instr_o        instruction to IF/ID
//   next_PC_o      fetched PC + PC_STEP to IF/ID
//   IFIDwrite_o    IF/ID capture enable
//   IFIDflush_o    IF/ID flush (= redirect_i outside BOOT)
// Optional: define IF_PERF_CNT_EN to add saturating counters perf_fetch_o
//           (cycles with IFIDwrite_o=1) and perf_stall_o (cycles with a
//           request outstanding and no ready).
// ============================================================================
module if_fetch_stage #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int unsigned PC_STEP  = 2
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             PCwrite_i,
    input  logic             redirect_i,
    input  logic [15:0]      redirect_pc_i,
    if_fetch_stage_if.master imem,
    output logic [15:0]      instr_o,
    output logic [15:0]      next_PC_o,
    output logic             IFIDwrite_o,
    output logic             IFIDflush_o
`ifdef IF_PERF_CNT_EN
    ,
    output logic [15:0]      perf_fetch_o,
    output logic [15:0]      perf_stall_o
`endif
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam logic [15:0] STEP = PC_STEP[15:0];

    // 16-bit modulo PC increment; wrap from FFFE to 0000 is silent.
    function automatic logic [15:0] pc_inc(input logic [15:0] pc);
        return pc + STEP;
    endfunction

    state_t      r_state;
    logic [15:0] r_pc;
    logic [15:0] r_req_addr;
    logic [15:0] r_hold_instr;
    logic [15:0] r_hold_npc;
    logic [15:0] r_last_instr;
    logic [15:0] r_last_npc;

    state_t      w_state_d;
    logic [15:0] w_pc_d;
    logic [15:0] w_req_addr_d;
    logic [15:0] w_hold_instr_d;
    logic [15:0] w_hold_npc_d;
    logic        w_req;
    logic        w_write;
    logic [15:0] w_instr;
    logic [15:0] w_npc;
    logic [15:0] w_target;
    logic [15:0] w_seq_npc;
    logic        w_unused_pc0;

    assign w_target     = {redirect_pc_i[15:1], 1'b0};
    assign w_unused_pc0 = redirect_pc_i[0];
    assign w_seq_npc    = pc_inc(r_req_addr);

    // Next-state, datapath updates and IF/ID outputs for the fetch FSM.
    always_comb begin
        w_state_d      = r_state;
        w_pc_d         = r_pc;
        w_req_addr_d   = r_req_addr;
        w_hold_instr_d = r_hold_instr;
        w_hold_npc_d   = r_hold_npc;
        w_req          = 1'b0;
        w_write        = 1'b0;
        // Undriven cycles repeat the last value presented to IF/ID.
        w_instr        = r_last_instr;
        w_npc          = r_last_npc;

        case (r_state)
            ST_BOOT: begin
                w_state_d = ST_FETCH;
                if (redirect_i) begin
                    w_pc_d       = w_target;
                    w_req_addr_d = w_target;
                end else begin
                    w_pc_d       = r_pc;
                    w_req_addr_d = r_req_addr;
                end
            end
            ST_FETCH: begin
                w_req = 1'b1;
                if (imem.imem_ready) begin
                    if (redirect_i) begin
                        // Response belongs to the wrong path: drop it.
                        w_pc_d       = w_target;
                        w_req_addr_d = w_target;
                    end else if (PCwrite_i) begin
                        w_write      = 1'b1;
                        w_instr      = imem.imem_rdata;
                        w_npc        = w_seq_npc;
                        w_pc_d       = w_seq_npc;
                        w_req_addr_d = w_seq_npc;
                    end else begin
                        // Stalled: park the word until IF/ID can take it.
                        w_hold_instr_d = imem.imem_rdata;
                        w_hold_npc_d   = w_seq_npc;
                        w_state_d      = ST_HOLD;
                    end
                end else begin
                    if (redirect_i) begin
                        // Outstanding request cannot be withdrawn; keep its
                        // address and drain the response first.
                        w_pc_d    = w_target;
                        w_state_d = ST_DRAIN;
                    end else begin
                        w_state_d = ST_FETCH;
                    end
                end
            end
            ST_HOLD: begin
                w_instr = r_hold_instr;
                w_npc   = r_hold_npc;
                if (redirect_i) begin
                    w_pc_d       = w_target;
                    w_req_addr_d = w_target;
                    w_state_d    = ST_FETCH;
                end else if (PCwrite_i) begin
                    w_write      = 1'b1;
                    w_pc_d       = r_hold_npc;
                    w_req_addr_d = r_hold_npc;
                    w_state_d    = ST_FETCH;
                end else begin
                    w_state_d = ST_HOLD;
                end
            end
            ST_DRAIN: begin
                w_req = 1'b1;
                if (imem.imem_ready) begin
                    w_state_d = ST_FETCH;
                    if (redirect_i) begin
                        w_pc_d       = w_target;
                        w_req_addr_d = w_target;
                    end else begin
                        w_req_addr_d = r_pc;
                    end
                end else begin
                    if (redirect_i) begin
                        w_pc_d = w_target;
                    end else begin
                        w_pc_d = r_pc;
                    end
                end
            end
            default: begin
                w_state_d = ST_BOOT;
            end
        endcase
    end

    // FSM state, PC, request address, stall buffer and last IF/ID values.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_BOOT;
            r_pc         <= RESET_PC;
            r_req_addr   <= RESET_PC;
            r_hold_instr <= 16'h0000;
            r_hold_npc   <= 16'h0000;
            r_last_instr <= 16'h0000;
            r_last_npc   <= 16'h0000;
        end else begin
            r_state      <= w_state_d;
            r_pc         <= w_pc_d;
            r_req_addr   <= w_req_addr_d;
            r_hold_instr <= w_hold_instr_d;
            r_hold_npc   <= w_hold_npc_d;
            r_last_instr <= w_instr;
            r_last_npc   <= w_npc;
        end
    end

    assign imem.imem_req  = w_req;
    assign imem.imem_addr = r_req_addr;
    assign instr_o        = w_instr;
    assign next_PC_o      = w_npc;
    assign IFIDwrite_o    = w_write;
    assign IFIDflush_o    = redirect_i && (r_state != ST_BOOT);

`ifdef IF_PERF_CNT_EN
    logic [15:0] r_perf_fetch;
    logic [15:0] r_perf_stall;

    // Saturating fetch/stall performance counters.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_fetch <= 16'h0000;
            r_perf_stall <= 16'h0000;
        end else begin
            if (w_write && (r_perf_fetch != 16'hFFFF)) begin
                r_perf_fetch <= r_perf_fetch + 16'd1;
            end
            if (w_req && !imem.imem_ready && (r_perf_stall != 16'hFFFF)) begin
                r_perf_stall <= r_perf_stall + 16'd1;
            end
        end
    end

    assign perf_fetch_o = r_perf_fetch;
    assign perf_stall_o = r_perf_stall;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// ============================================================================
// tb_if_fetch_stage
// Self-checking bench for if_fetch_stage: directed scenarios (reset, zero-wait
// streaming, wait states, stall/hold, redirects, PC wrap, reset mid-request)
// followed by randomized traffic checked against a transaction-level model
// of the architectural PC sequence.
// ============================================================================
module tb_if_fetch_stage;

    logic        clk_i;
    logic        rst_n;
    logic        PCwrite_i;
    logic        redirect_i;
    logic [15:0] redirect_pc_i;
    logic [15:0] instr_o;
    logic [15:0] next_PC_o;
    logic        IFIDwrite_o;
    logic        IFIDflush_o;
`ifdef IF_PERF_CNT_EN
    logic [15:0] perf_fetch_o;
    logic [15:0] perf_stall_o;
`endif

    if_fetch_stage_if imem ();

    if_fetch_stage #(
        .RESET_PC (16'h0000),
        .PC_STEP  (2)
    ) dut (
        .clk_i         (clk_i),
        .rst_n         (rst_n),
        .PCwrite_i     (PCwrite_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem          (imem),
        .instr_o       (instr_o),
        .next_PC_o     (next_PC_o),
        .IFIDwrite_o   (IFIDwrite_o),
        .IFIDflush_o   (IFIDflush_o)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetch_o  (perf_fetch_o),
        .perf_stall_o  (perf_stall_o)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Instruction memory contents: a fixed scramble of the address.
    function automatic logic [15:0] memf(input logic [15:0] a);
        logic [31:0] p;
        p = {16'h0000, a} * 32'h0000_9E37;
        return p[15:0] ^ 16'h5A5A;
    endfunction

    // One cycle of stimulus: inputs driven on the falling edge, outputs
    // settle for 1 time unit before the caller samples them.
    task automatic drive(input logic pcw, input logic red, input logic [15:0] tgt, input logic rdy);
        @(negedge clk_i);
        PCwrite_i       = pcw;
        redirect_i      = red;
        redirect_pc_i   = tgt;
        imem.imem_ready = rdy;
        imem.imem_rdata = rdy ? memf(imem.imem_addr) : 16'hDEAD;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; PCwrite_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 16'h1234;
        imem.imem_ready = 1'b1; imem.imem_rdata = 16'hBEEF;
        #12;
        n_checks++;
        if (imem.imem_req !== 1'b0 || IFIDwrite_o !== 1'b0 || IFIDflush_o !== 1'b0 ||
            instr_o !== 16'h0000 || next_PC_o !== 16'h0000) begin
            $display("FAIL reset: req=%b wr=%b fl=%b instr=%h npc=%h, want all 0",
                     imem.imem_req, IFIDwrite_o, IFIDflush_o, instr_o, next_PC_o);
        end else n_pass++;
`ifdef IF_PERF_CNT_EN
        n_checks++;
        if (perf_fetch_o !== 16'h0000 || perf_stall_o !== 16'h0000) begin
            $display("FAIL perf_reset: fetch=%0d stall=%0d, want 0/0", perf_fetch_o, perf_stall_o);
        end else n_pass++;
`endif
        redirect_i = 1'b0;
    endtask

    task automatic test_zero_wait();
        logic [15:0] a;
        @(negedge clk_i);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (imem.imem_req !== 1'b0 || IFIDwrite_o !== 1'b0) begin
            $display("FAIL boot: req=%b wr=%b, want 0 0", imem.imem_req, IFIDwrite_o);
        end else n_pass++;
        for (int i = 0; i < 2; i++) begin
            a = 16'(2 * i);
            drive(1'b1, 1'b0, 16'h0000, 1'b1);
            n_checks++;
            if (imem.imem_req !== 1'b1 || imem.imem_addr !== a || IFIDwrite_o !== 1'b1 ||
                instr_o !== memf(a) || next_PC_o !== a + 16'd2) begin
                $display("FAIL zero_wait[%0d]: addr=%h wr=%b instr=%h npc=%h, want addr=%h wr=1 instr=%h npc=%h",
                         i, imem.imem_addr, IFIDwrite_o, instr_o, next_PC_o, a, memf(a), a + 16'd2);
            end else n_pass++;
        end
    endtask

    task automatic test_wait_states();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 16'h0000, 1'b0);
            n_checks++;
            if (imem.imem_req !== 1'b1 || imem.imem_addr !== 16'h0004 || IFIDwrite_o !== 1'b0) begin
                $display("FAIL wait[%0d]: req=%b addr=%h wr=%b, want 1 0004 0",
                         i, imem.imem_req, imem.imem_addr, IFIDwrite_o);
            end else n_pass++;
        end
        drive(1'b1, 1'b0, 16'h0000, 1'b1);
        n_checks++;
        if (IFIDwrite_o !== 1'b1 || instr_o !== memf(16'h0004) || next_PC_o !== 16'h0006) begin
            $display("FAIL wait_ready: wr=%b instr=%h npc=%h, want 1 %h 0006",
                     IFIDwrite_o, instr_o, next_PC_o, memf(16'h0004));
        end else n_pass++;
    endtask

    task automatic test_stall_hold();
        drive(1'b0, 1'b0, 16'h0000, 1'b1);
        n_checks++;
        if (imem.imem_addr !== 16'h0006 || IFIDwrite_o !== 1'b0) begin
            $display("FAIL stall_capture: addr=%h wr=%b, want 0006 0", imem.imem_addr, IFIDwrite_o);
        end else n_pass++;
`ifdef IF_PERF_CNT_EN
        n_checks++;
        if (perf_fetch_o !== 16'd3 || perf_stall_o !== 16'd3) begin
            $display("FAIL perf_counts: fetch=%0d stall=%0d, want 3/3", perf_fetch_o, perf_stall_o);
        end else n_pass++;
`endif
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 16'h0000, 1'b0);
            n_checks++;
            if (imem.imem_req !== 1'b0 || IFIDwrite_o !== 1'b0 ||
                instr_o !== memf(16'h0006) || next_PC_o !== 16'h0008) begin
                $display("FAIL hold[%0d]: req=%b wr=%b instr=%h npc=%h, want 0 0 %h 0008",
                         i, imem.imem_req, IFIDwrite_o, instr_o, next_PC_o, memf(16'h0006));
            end else n_pass++;
        end
        drive(1'b1, 1'b0, 16'h0000, 1'b0);
        n_checks++;
        if (IFIDwrite_o !== 1'b1 || instr_o !== memf(16'h0006) || next_PC_o !== 16'h0008) begin
            $display("FAIL hold_release: wr=%b instr=%h npc=%h, want 1 %h 0008",
                     IFIDwrite_o, instr_o, next_PC_o, memf(16'h0006));
        end else n_pass++;
    endtask

    task automatic test_redirect_pending();
        logic [15:0] a;
        for (int i = 0; i < 4; i++) begin
            a = 16'(8 + 2 * i);
            drive(1'b1, 1'b0, 16'h0000, 1'b1);
            n_checks++;
            if (imem.imem_addr !== a || IFIDwrite_o !== 1'b1 || instr_o !== memf(a)) begin
                $display("FAIL seq[%0d]: addr=%h wr=%b instr=%h, want %h 1 %h",
                         i, imem.imem_addr, IFIDwrite_o, instr_o, a, memf(a));
            end else n_pass++;
        end
        drive(1'b1, 1'b1, 16'h0040, 1'b0);
        n_checks++;
        if (IFIDflush_o !== 1'b1 || IFIDwrite_o !== 1'b0 || imem.imem_addr !== 16'h0010) begin
            $display("FAIL redir_pending: fl=%b wr=%b addr=%h, want 1 0 0010",
                     IFIDflush_o, IFIDwrite_o, imem.imem_addr);
        end else n_pass++;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, 16'h0000, 1'b0);
            n_checks++;
            if (imem.imem_req !== 1'b1 || imem.imem_addr !== 16'h0010 || IFIDwrite_o !== 1'b0 ||
                IFIDflush_o !== 1'b0) begin
                $display("FAIL drain[%0d]: req=%b addr=%h wr=%b fl=%b, want 1 0010 0 0",
                         i, imem.imem_req, imem.imem_addr, IFIDwrite_o, IFIDflush_o);
            end else n_pass++;
        end
        drive(1'b1, 1'b0, 16'h0000, 1'b1);
        n_checks++;
        if (IFIDwrite_o !== 1'b0) begin
            $display("FAIL drain_discard: wr=%b, want 0", IFIDwrite_o);
        end else n_pass++;
        drive(1'b1, 1'b0, 16'h0000, 1'b1);
        n_checks++;
        if (imem.imem_addr !== 16'h0040 || IFIDwrite_o !== 1'b1 || instr_o !== memf(16'h0040) ||
            next_PC_o !== 16'h0042) begin
            $display("FAIL redir_target: addr=%h wr=%b instr=%h npc=%h, want 0040 1 %h 0042",
                     imem.imem_addr, IFIDwrite_o, instr_o, next_PC_o, memf(16'h0040));
        end else n_pass++;
    endtask

    task automatic test_redirect_hold();
        drive(1'b0, 1'b0, 16'h0000, 1'b1);
        drive(1'b0, 1'b1, 16'h0081, 1'b0);
        n_checks++;
        if (IFIDwrite_o !== 1'b0 || IFIDflush_o !== 1'b1 || imem.imem_req !== 1'b0) begin
            $display("FAIL redir_hold: wr=%b fl=%b req=%b, want 0 1 0", IFIDwrite_o, IFIDflush_o, imem.imem_req);
        end else n_pass++;
        drive(1'b1, 1'b0, 16'h0000, 1'b1);
        n_checks++;
        if (imem.imem_addr !== 16'h0080 || IFIDwrite_o !== 1'b1 || instr_o !== memf(16'h0080) ||
            next_PC_o !== 16'h0082) begin
            $display("FAIL redir_hold_target: addr=%h wr=%b instr=%h npc=%h, want 0080 1 %h 0082",
                     imem.imem_addr, IFIDwrite_o, instr_o, next_PC_o, memf(16'h0080));
        end else n_pass++;
    endtask

    task automatic test_wrap();
        drive(1'b1, 1'b1, 16'hFFFE, 1'b1);
        n_checks++;
        if (IFIDwrite_o !== 1'b0 || IFIDflush_o !== 1'b1) begin
            $display("FAIL redir_ready: wr=%b fl=%b, want 0 1", IFIDwrite_o, IFIDflush_o);
        end else n_pass++;
        drive(1'b1, 1'b0, 16'h0000, 1'b1);
        n_checks++;
        if (imem.imem_addr !== 16'hFFFE || IFIDwrite_o !== 1'b1 || next_PC_o !== 16'h0000) begin
            $display("FAIL wrap: addr=%h wr=%b npc=%h, want FFFE 1 0000", imem.imem_addr, IFIDwrite_o, next_PC_o);
        end else n_pass++;
        drive(1'b1, 1'b0, 16'h0000, 1'b1);
        n_checks++;
        if (imem.imem_addr !== 16'h0000 || IFIDwrite_o !== 1'b1 || next_PC_o !== 16'h0002) begin
            $display("FAIL wrap_next: addr=%h wr=%b npc=%h, want 0000 1 0002", imem.imem_addr, IFIDwrite_o, next_PC_o);
        end else n_pass++;
    endtask

    task automatic test_reset_mid_request();
        drive(1'b1, 1'b0, 16'h0000, 1'b0);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (imem.imem_req !== 1'b0 || IFIDwrite_o !== 1'b0 || IFIDflush_o !== 1'b0 ||
            instr_o !== 16'h0000 || next_PC_o !== 16'h0000) begin
            $display("FAIL reset_mid: req=%b wr=%b fl=%b instr=%h npc=%h, want all 0",
                     imem.imem_req, IFIDwrite_o, IFIDflush_o, instr_o, next_PC_o);
        end else n_pass++;
        @(negedge clk_i);
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 16'h0000, 1'b1);
        n_checks++;
        if (imem.imem_addr !== 16'h0000 || IFIDwrite_o !== 1'b1 || instr_o !== memf(16'h0000)) begin
            $display("FAIL reset_refetch: addr=%h wr=%b instr=%h, want 0000 1 %h",
                     imem.imem_addr, IFIDwrite_o, instr_o, memf(16'h0000));
        end else n_pass++;
    endtask

    // Random traffic against a model of the architectural instruction stream:
    // each IF/ID write must carry mem[expected PC]; redirects retarget it.
    task automatic test_random();
        logic [15:0] exp_pc;
        logic [15:0] prev_instr;
        logic [15:0] prev_npc;
        logic [15:0] prev_addr;
        logic        prev_pend;
        int          wait_left;
        int          writes;
        @(negedge clk_i);
        rst_n = 1'b0; redirect_i = 1'b0; PCwrite_i = 1'b0; imem.imem_ready = 1'b0;
        @(negedge clk_i);
        rst_n = 1'b1;
        exp_pc = 16'h0000; prev_instr = 16'h0000; prev_npc = 16'h0000; prev_addr = 16'h0000;
        prev_pend = 1'b0; wait_left = 0; writes = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk_i);
            PCwrite_i     = ($urandom_range(0, 9) < 7);
            redirect_i    = ($urandom_range(0, 15) == 0);
            redirect_pc_i = 16'($urandom);
            if (imem.imem_req === 1'b1) begin
                if (wait_left == 0) begin
                    imem.imem_ready = 1'b1;
                    imem.imem_rdata = memf(imem.imem_addr);
                    wait_left = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
                end else begin
                    imem.imem_ready = 1'b0;
                    imem.imem_rdata = 16'($urandom);
                    wait_left--;
                end
            end else begin
                imem.imem_ready = 1'b0;
                imem.imem_rdata = 16'($urandom);
            end
            #1;
            n_checks++;
            if (IFIDflush_o !== redirect_i) begin
                $display("FAIL rnd_flush @%0d: fl=%b, want %b", i, IFIDflush_o, redirect_i);
            end else n_pass++;
            n_checks++;
            if (IFIDwrite_o === 1'b1) begin
                if (redirect_i !== 1'b0 || PCwrite_i !== 1'b1 || instr_o !== memf(exp_pc) ||
                    next_PC_o !== exp_pc + 16'd2) begin
                    $display("FAIL rnd_write @%0d: instr=%h npc=%h red=%b pcw=%b, want instr=%h npc=%h red=0 pcw=1",
                             i, instr_o, next_PC_o, redirect_i, PCwrite_i, memf(exp_pc), exp_pc + 16'd2);
                end else n_pass++;
                exp_pc = exp_pc + 16'd2;
                writes++;
            end else begin
                if (!((instr_o === prev_instr && next_PC_o === prev_npc) ||
                      (instr_o === memf(exp_pc) && next_PC_o === exp_pc + 16'd2))) begin
                    $display("FAIL rnd_idle @%0d: wr=%b instr=%h npc=%h, want held %h/%h or buffered %h/%h",
                             i, IFIDwrite_o, instr_o, next_PC_o, prev_instr, prev_npc, memf(exp_pc), exp_pc + 16'd2);
                end else n_pass++;
            end
            if (prev_pend) begin
                n_checks++;
                if (imem.imem_req !== 1'b1 || imem.imem_addr !== prev_addr) begin
                    $display("FAIL rnd_addr_stable @%0d: req=%b addr=%h, want 1 %h",
                             i, imem.imem_req, imem.imem_addr, prev_addr);
                end else n_pass++;
            end
            if (redirect_i) exp_pc = redirect_pc_i & 16'hFFFE;
            prev_instr = instr_o;
            prev_npc   = next_PC_o;
            prev_addr  = imem.imem_addr;
            prev_pend  = (imem.imem_req === 1'b1) && (imem.imem_ready === 1'b0);
        end
        n_checks++;
        if (writes < 300) begin
            $display("FAIL rnd_progress: writes=%0d, want >= 300", writes);
        end else n_pass++;
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_stall_hold();
        test_redirect_pending();
        test_redirect_hold();
        test_wrap();
        test_reset_mid_request();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
